// File: rtl/sddr_pkg.sv
// Shared types and geometry for the single-line DDR burst adapter.
package sddr_pkg;

    localparam int unsigned WORD_BITS        = 32;
    localparam int unsigned WORDS_PER_LINE   = 4;
    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam int unsigned LINE_W           = WORD_BITS * WORDS_PER_LINE;
    localparam int unsigned WORD_IDX_BITS    = 2;
    localparam int unsigned MASK_BITS        = WORD_BITS / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD,
        RESP
    } state_e;

    // Extract one 32-bit word from a burst line.
    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [LINE_W-1:0]        line,
        input logic [WORD_IDX_BITS-1:0] idx
    );
        return line[32'(idx) * WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/sddr_line_merge.sv
// Byte-enable merge of one CPU word into a burst line.
module sddr_line_merge
    import sddr_pkg::*;
(
    input  logic [LINE_W-1:0]        line_i,
    input  logic [WORD_IDX_BITS-1:0] word_idx_i,
    input  logic [WORD_BITS-1:0]     data_i,
    input  logic [MASK_BITS-1:0]     mask_i,
    output logic [LINE_W-1:0]        merged_line_c
);

    always_comb begin
        merged_line_c = line_i;
        for (int b = 0; b < int'(MASK_BITS); b++) begin
            if (mask_i[b]) begin
                merged_line_c[32'(word_idx_i) * WORD_BITS + 32'(b) * 8 +: 8] = data_i[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sddr_line_adapter.sv
// Adapts 32-bit CPU accesses onto a burst-line DDR controller through a
// single-line buffer; partial writes become read-modify-write.
module sddr_line_adapter
    import sddr_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 27,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 cpu_clock_i,
    input  logic                 reset_i,
    input  logic                 cpu_req_valid_i,
    output logic                 cpu_req_ack_o,
    input  logic                 cpu_req_write_i,
    input  logic [ADDR_BITS-1:0] cpu_req_addr_i,
    input  logic [31:0]          cpu_req_data_i,
    input  logic [3:0]           cpu_req_mask_i,
    output logic                 cpu_rsp_valid_o,
    output logic [31:0]          cpu_rsp_data_o,
    output logic                 data_cmd_valid_o,
    input  logic                 data_cmd_ack_i,
    output logic                 data_cmd_write_o,
    output logic [ADDR_BITS-1:0] data_cmd_address_o,
    output logic [LINE_BITS-1:0] data_cmd_data_o,
    input  logic                 data_rsp_ready_i,
    input  logic [LINE_BITS-1:0] data_rsp_data_i
);

    localparam int unsigned TAG_BITS = ADDR_BITS - LINE_OFFSET_BITS;

    state_e                 state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   line_valid_q, line_valid_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic                   req_write_q, req_write_d;
    logic [ADDR_BITS-1:0]   req_addr_q, req_addr_d;
    logic [WORD_BITS-1:0]   req_data_q, req_data_d;
    logic [MASK_BITS-1:0]   req_mask_q, req_mask_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WORD_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   cmd_write_q, cmd_write_d;
    logic [ADDR_BITS-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LINE_BITS-1:0]   cmd_data_q, cmd_data_d;

    logic [TAG_BITS-1:0]      cpu_tag_c;
    logic [TAG_BITS-1:0]      req_tag_c;
    logic                     hit_c;
    logic [LINE_BITS-1:0]     merge_base_c;
    logic [WORD_IDX_BITS-1:0] merge_idx_c;
    logic [WORD_BITS-1:0]     merge_data_c;
    logic [MASK_BITS-1:0]     merge_mask_c;
    logic [LINE_BITS-1:0]     merged_line_c;

    assign cpu_tag_c = cpu_req_addr_i[ADDR_BITS-1:LINE_OFFSET_BITS];
    assign req_tag_c = req_addr_q[ADDR_BITS-1:LINE_OFFSET_BITS];
    assign hit_c     = line_valid_q && (tag_q == cpu_tag_c);

    // IDLE merges a write hit into the buffer; RD_WAIT merges into the fetched line.
    always_comb begin
        if (state_q == IDLE) begin
            merge_base_c = line_q;
            merge_idx_c  = cpu_req_addr_i[LINE_OFFSET_BITS-1:2];
            merge_data_c = cpu_req_data_i;
            merge_mask_c = cpu_req_mask_i;
        end else begin
            merge_base_c = data_rsp_data_i;
            merge_idx_c  = req_addr_q[LINE_OFFSET_BITS-1:2];
            merge_data_c = req_data_q;
            merge_mask_c = req_mask_q;
        end
    end

    sddr_line_merge u_merge (
        .line_i        (merge_base_c),
        .word_idx_i    (merge_idx_c),
        .data_i        (merge_data_c),
        .mask_i        (merge_mask_c),
        .merged_line_c (merged_line_c)
    );

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        line_d       = line_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_mask_d   = req_mask_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req_valid_i) begin
                    req_write_d = cpu_req_write_i;
                    req_addr_d  = cpu_req_addr_i;
                    req_data_d  = cpu_req_data_i;
                    req_mask_d  = cpu_req_mask_i;
                    if (cpu_req_write_i && (cpu_req_mask_i == '0)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else if (hit_c && !cpu_req_write_i) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = line_word(line_q, cpu_req_addr_i[LINE_OFFSET_BITS-1:2]);
                    end else if (hit_c) begin
                        state_d     = WR_CMD;
                        line_d      = merged_line_c;
                        cmd_valid_d = 1'b1;
                        cmd_write_d = 1'b1;
                        cmd_addr_d  = {cpu_tag_c, {LINE_OFFSET_BITS{1'b0}}};
                        cmd_data_d  = merged_line_c;
                    end else begin
                        state_d     = RD_CMD;
                        cmd_valid_d = 1'b1;
                        cmd_write_d = 1'b0;
                        cmd_addr_d  = {cpu_tag_c, {LINE_OFFSET_BITS{1'b0}}};
                    end
                end
            end
            RD_CMD: begin
                if (data_cmd_ack_i) begin
                    state_d     = RD_WAIT;
                    cmd_valid_d = 1'b0;
                end
            end
            RD_WAIT: begin
                if (data_rsp_ready_i) begin
                    line_valid_d = 1'b1;
                    tag_d        = req_tag_c;
                    if (req_write_q) begin
                        state_d     = WR_CMD;
                        line_d      = merged_line_c;
                        cmd_valid_d = 1'b1;
                        cmd_write_d = 1'b1;
                        cmd_data_d  = merged_line_c;
                    end else begin
                        state_d     = RESP;
                        line_d      = data_rsp_data_i;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = line_word(data_rsp_data_i, req_addr_q[LINE_OFFSET_BITS-1:2]);
                    end
                end
            end
            WR_CMD: begin
                if (data_cmd_ack_i) begin
                    state_d     = RESP;
                    cmd_valid_d = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d = (state_d == IDLE);
    end

    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            ack_q        <= 1'b1;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            line_q       <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_mask_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_mask_q   <= req_mask_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
        end
    end

    assign cpu_req_ack_o      = ack_q;
    assign cpu_rsp_valid_o    = rsp_valid_q;
    assign cpu_rsp_data_o     = rsp_data_q;
    assign data_cmd_valid_o   = cmd_valid_q;
    assign data_cmd_write_o   = cmd_write_q;
    assign data_cmd_address_o = cmd_addr_q;
    assign data_cmd_data_o    = cmd_data_q;

endmodule

// File: tb/tb_sddr_line_adapter.sv
// Scoreboard bench for sddr_line_adapter: directed CPU traffic with a scripted controller.
module tb_sddr_line_adapter;

    localparam int unsigned AW = 27;
    localparam int unsigned LW = 128;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          cpu_req_valid_i;
    logic          cpu_req_ack_o;
    logic          cpu_req_write_i;
    logic [AW-1:0] cpu_req_addr_i;
    logic [31:0]   cpu_req_data_i;
    logic [3:0]    cpu_req_mask_i;
    logic          cpu_rsp_valid_o;
    logic [31:0]   cpu_rsp_data_o;
    logic          data_cmd_valid_o;
    logic          data_cmd_ack_i;
    logic          data_cmd_write_o;
    logic [AW-1:0] data_cmd_address_o;
    logic [LW-1:0] data_cmd_data_o;
    logic          data_rsp_ready_i;
    logic [LW-1:0] data_rsp_data_i;

    always #5 clk = ~clk;

    sddr_line_adapter #(.ADDR_BITS(AW), .LINE_BITS(LW)) dut (
        .cpu_clock_i        (clk),
        .reset_i            (reset_i),
        .cpu_req_valid_i    (cpu_req_valid_i),
        .cpu_req_ack_o      (cpu_req_ack_o),
        .cpu_req_write_i    (cpu_req_write_i),
        .cpu_req_addr_i     (cpu_req_addr_i),
        .cpu_req_data_i     (cpu_req_data_i),
        .cpu_req_mask_i     (cpu_req_mask_i),
        .cpu_rsp_valid_o    (cpu_rsp_valid_o),
        .cpu_rsp_data_o     (cpu_rsp_data_o),
        .data_cmd_valid_o   (data_cmd_valid_o),
        .data_cmd_ack_i     (data_cmd_ack_i),
        .data_cmd_write_o   (data_cmd_write_o),
        .data_cmd_address_o (data_cmd_address_o),
        .data_cmd_data_o    (data_cmd_data_o),
        .data_rsp_ready_i   (data_rsp_ready_i),
        .data_rsp_data_i    (data_rsp_data_i)
    );

    typedef struct {
        int          cyc;
        logic        chk_data;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } cmd_t;

    rsp_t rsp_q[$];
    cmd_t cmd_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_rsp(input int c, input logic chk, input logic [31:0] d);
        rsp_t r;
        r.cyc = c; r.chk_data = chk; r.data = d;
        rsp_q.push_back(r);
    endtask

    task automatic exp_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.data = d;
        cmd_q.push_back(c);
    endtask

    // Monitor: pops scoreboard entries on responses and command handshakes, checks hold stability.
    initial begin
        logic          pend;
        logic          snap_wr;
        logic [AW-1:0] snap_addr;
        logic [LW-1:0] snap_data;
        rsp_t          r;
        cmd_t          c;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("cmd_hold_ctl", {data_cmd_valid_o, data_cmd_write_o, data_cmd_address_o},
                          {1'b1, snap_wr, snap_addr});
                    check("cmd_hold_data", data_cmd_data_o, snap_data);
                end
                if (data_cmd_valid_o && data_cmd_ack_i) begin
                    pend = 1'b0;
                    if (cmd_q.size() == 0) begin
                        check("unexpected_cmd", 1, 0);
                    end else begin
                        c = cmd_q.pop_front();
                        check("cmd_write", data_cmd_write_o, c.wr);
                        check("cmd_addr", data_cmd_address_o, c.addr);
                        if (c.wr) check("cmd_data", data_cmd_data_o, c.data);
                    end
                end else if (data_cmd_valid_o) begin
                    pend      = 1'b1;
                    snap_wr   = data_cmd_write_o;
                    snap_addr = data_cmd_address_o;
                    snap_data = data_cmd_data_o;
                end else begin
                    pend = 1'b0;
                end
                if (cpu_rsp_valid_o) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_cycle", r.cyc, cyc);
                        if (r.chk_data) check("rsp_data", cpu_rsp_data_o, r.data);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the cycle index of the accepting edge; outputs of that edge are visible on return.
    task automatic cpu_req(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int acc);
        int n;
        n   = 0;
        acc = -1;
        cpu_req_valid_i = 1'b1;
        cpu_req_write_i = wr;
        cpu_req_addr_i  = a;
        cpu_req_data_i  = d;
        cpu_req_mask_i  = m;
        while (acc < 0 && n < 50) begin
            if (cpu_req_ack_o) acc = cyc + 1;
            step(1);
            n++;
        end
        cpu_req_valid_i = 1'b0;
        if (acc < 0) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (!data_cmd_valid_o && n < 50) begin
            step(1);
            n++;
        end
        if (!data_cmd_valid_o) check("cmd_timeout", 0, 1);
    endtask

    task automatic ack_cmd(output int hs);
        data_cmd_ack_i = 1'b1;
        hs = cyc + 1;
        step(1);
        data_cmd_ack_i = 1'b0;
    endtask

    task automatic fill(input logic [LW-1:0] line, input logic do_rsp, input logic [31:0] w);
        step(2);
        if (do_rsp) exp_rsp(cyc + 1, 1'b1, w);
        data_rsp_ready_i = 1'b1;
        data_rsp_data_i  = line;
        step(1);
        data_rsp_ready_i = 1'b0;
        data_rsp_data_i  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc, acc2, hs, seen;
        logic [LW-1:0] l1, l2, m2, m3, l3;
        l1 = {32'h0000_4444, 32'h0000_3333, 32'h0000_2222, 32'h0000_1111};
        l2 = {32'hFEED_F00D, 32'hC0DE_C0DE, 32'h1234_5678, 32'h0BAD_0000};
        m2 = {32'hFEED_F00D, 32'hC0DE_C0DE, 32'h1234_CCDD, 32'h0BAD_0000};
        m3 = {32'hFEED_F00D, 32'h1122_C0DE, 32'h1234_CCDD, 32'h0BAD_0000};
        l3 = {32'h0000_0D0D, 32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A};

        reset_i = 1'b1; cpu_req_valid_i = 1'b0; cpu_req_write_i = 1'b0;
        cpu_req_addr_i = '0; cpu_req_data_i = '0; cpu_req_mask_i = '0;
        data_cmd_ack_i = 1'b0; data_rsp_ready_i = 1'b0; data_rsp_data_i = '0;
        step(3);
        check("reset_rsp_valid", cpu_rsp_valid_o, 0);
        check("reset_rsp_data", cpu_rsp_data_o, 0);
        check("reset_cmd_ctl", {data_cmd_valid_o, data_cmd_write_o, data_cmd_address_o}, 0);
        check("reset_cmd_data", data_cmd_data_o, 0);
        check("reset_req_ack", cpu_req_ack_o, 1);
        reset_i = 1'b0;
        step(1);

        // Read miss at 0x40 with a short command stall.
        exp_cmd(1'b0, 27'h40, '0);
        cpu_req(1'b0, 27'h40, 32'h0, 4'h0, acc);
        check("rd_miss_cmd_next", {data_cmd_valid_o, data_cmd_write_o}, 2'b10);
        check("rd_miss_req_ack_low", cpu_req_ack_o, 0);
        step(2);
        ack_cmd(hs);
        fill(l1, 1'b1, 32'h0000_1111);
        step(2);

        // Read hit, then back-to-back hits.
        cpu_req(1'b0, 27'h48, 32'h0, 4'h0, acc);
        exp_rsp(acc, 1'b1, 32'h0000_3333);
        check("rd_hit_no_cmd", data_cmd_valid_o, 0);
        step(2);
        cpu_req(1'b0, 27'h40, 32'h0, 4'h0, acc);
        exp_rsp(acc, 1'b1, 32'h0000_1111);
        cpu_req(1'b0, 27'h4C, 32'h0, 4'h0, acc2);
        exp_rsp(acc2, 1'b1, 32'h0000_4444);
        check("b2b_hit_spacing", acc2 - acc, 2);
        step(2);

        // Write miss: fetch, merge, then write command held under 10 cycles of backpressure.
        exp_cmd(1'b0, 27'h100, '0);
        exp_cmd(1'b1, 27'h100, m2);
        cpu_req(1'b1, 27'h104, 32'hAABB_CCDD, 4'b0011, acc);
        wait_cmd();
        ack_cmd(hs);
        fill(l2, 1'b0, 32'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (data_cmd_valid_o && data_cmd_write_o && !cpu_req_ack_o) seen++;
            step(1);
        end
        check("backpressure_hold", seen, 10);
        ack_cmd(hs);
        exp_rsp(hs, 1'b0, 32'h0);
        step(2);
        cpu_req(1'b0, 27'h104, 32'h0, 4'h0, acc);
        exp_rsp(acc, 1'b1, 32'h1234_CCDD);
        step(2);

        // Write hit goes straight to a write command.
        exp_cmd(1'b1, 27'h100, m3);
        cpu_req(1'b1, 27'h108, 32'h1122_3344, 4'b1100, acc);
        check("wr_hit_cmd_next", {data_cmd_valid_o, data_cmd_write_o}, 2'b11);
        ack_cmd(hs);
        exp_rsp(hs, 1'b0, 32'h0);
        step(2);
        cpu_req(1'b0, 27'h108, 32'h0, 4'h0, acc);
        exp_rsp(acc, 1'b1, 32'h1122_C0DE);
        step(2);

        // Mask-0 writes complete immediately with no command, hit or miss.
        cpu_req(1'b1, 27'h10C, 32'hFFFF_FFFF, 4'b0000, acc);
        exp_rsp(acc, 1'b0, 32'h0);
        check("mask0_hit_no_cmd", data_cmd_valid_o, 0);
        step(2);
        cpu_req(1'b0, 27'h10C, 32'h0, 4'h0, acc);
        exp_rsp(acc, 1'b1, 32'hFEED_F00D);
        step(2);
        cpu_req(1'b1, 27'h500, 32'hFFFF_FFFF, 4'b0000, acc);
        exp_rsp(acc, 1'b0, 32'h0);
        check("mask0_miss_no_cmd", data_cmd_valid_o, 0);
        step(3);

        // Reset while waiting for fill data, then a stray ready pulse.
        exp_cmd(1'b0, 27'h200, '0);
        cpu_req(1'b0, 27'h200, 32'h0, 4'h0, acc);
        wait_cmd();
        ack_cmd(hs);
        step(2);
        reset_i = 1'b1;
        step(2);
        reset_i = 1'b0;
        check("mid_reset_idle", {cpu_req_ack_o, data_cmd_valid_o, cpu_rsp_valid_o}, 3'b100);
        data_rsp_ready_i = 1'b1;
        data_rsp_data_i  = l3;
        step(1);
        data_rsp_ready_i = 1'b0;
        data_rsp_data_i  = '0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_rsp_valid_o) seen++;
            step(1);
        end
        check("stray_ready_no_rsp", seen, 0);
        exp_cmd(1'b0, 27'h200, '0);
        cpu_req(1'b0, 27'h204, 32'h0, 4'h0, acc);
        check("after_reset_miss", data_cmd_valid_o, 1);
        ack_cmd(hs);
        fill(l3, 1'b1, 32'h0000_0B0B);
        step(3);

        check("rsp_queue_empty", rsp_q.size(), 0);
        check("cmd_queue_empty", cmd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sddr_line_adapter.md
SDDR_LINE_ADAPTER -- requirements
Module: sddr_line_adapter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 27: byte-address width, equal to the controller's data_cmd_address width.
REQ-002 SHALL have parameter LINE_BITS, default 128: burst line width (BURST_LENGTH*DATA_BITS); fixed at 4 words of 32 bits.
REQ-003 SHALL have port cpu_clock_i, input, 1: sole clock.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cpu_req_valid_i, input, 1: CPU request present.
REQ-006 SHALL have port cpu_req_ack_o, output, 1: request accepted when high with valid.
REQ-007 SHALL have port cpu_req_write_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cpu_req_addr_i, input, ADDR_BITS: byte address; bits [1:0] ignored.
REQ-009 SHALL have port cpu_req_data_i, input, 32: write data.
REQ-010 SHALL have port cpu_req_mask_i, input, 4: byte enables; bit k covers data[8k+7:8k].
REQ-011 SHALL have port cpu_rsp_valid_o, output, 1: one-cycle completion pulse for reads and writes.
REQ-012 SHALL have port cpu_rsp_data_o, output, 32: read data, valid with cpu_rsp_valid_o.
REQ-013 SHALL have port data_cmd_valid_o, output, 1: burst command to the controller.
REQ-014 SHALL have port data_cmd_ack_i, input, 1: controller ready; command transfers in a cycle with valid && ack.
REQ-015 SHALL have port data_cmd_write_o, output, 1: burst direction.
REQ-016 SHALL have port data_cmd_address_o, output, ADDR_BITS: line address with bits [3:0] = 0.
REQ-017 SHALL have port data_cmd_data_o, output, LINE_BITS: write line; word w at bits [32w+31:32w].
REQ-018 SHALL have port data_rsp_ready_i, input, 1: one-cycle pulse, read line valid.
REQ-019 SHALL have port data_rsp_data_i, input, LINE_BITS: read line.

Function
REQ-020 SHALL hold one line buffer: valid bit, tag = addr[ADDR_BITS-1:4], 128-bit data.
REQ-021 SHALL implement the FSM states IDLE, RD_CMD, RD_WAIT, WR_CMD and RESP; cpu_req_ack_o = 1 only in IDLE.
REQ-022 On an accepted read hit in cycle N, SHALL go to RESP and pulse cpu_rsp_valid_o in cycle N+1 with word addr[3:2]; no DDR command is issued.
REQ-023 On an accepted read miss, SHALL enter RD_CMD with data_cmd_valid_o=1 and data_cmd_write_o=0 from N+1, holding the command until it is acknowledged, then enter RD_WAIT.
REQ-024 In RD_WAIT, on the data_rsp_ready_i pulse in cycle M, SHALL load the buffer, set valid and tag, and pulse cpu_rsp_valid_o in M+1 for a read.
REQ-025 A write miss SHALL first fetch the line (RD_CMD/RD_WAIT) as read-modify-write, because the controller has no data mask.
REQ-026 A write hit, or a write miss after its fill, SHALL merge the enabled bytes into the buffer and enter WR_CMD with data_cmd_write_o=1 and data_cmd_data_o = merged line.
REQ-027 SHALL pulse cpu_rsp_valid_o in the cycle after the WR_CMD handshake; writes expect no controller response.
REQ-028 A write with mask 4'b0000 SHALL complete as a hit-free no-op: RESP in N+1, no DDR command, buffer unchanged.
REQ-029 data_cmd_valid_o, data_cmd_address_o, data_cmd_write_o and data_cmd_data_o SHALL stay stable from assertion until the handshake.
REQ-030 data_rsp_ready_i outside RD_WAIT SHALL be ignored.
REQ-031 The response-to-command gap SHALL be 0 cycles: RESP returns to IDLE in the following cycle, so back-to-back hits sustain one request per 2 cycles.

Reset
REQ-032 Reset SHALL set the FSM to IDLE, clear line valid, and drive cpu_rsp_valid_o=0, data_cmd_valid_o=0, data_cmd_write_o=0, data_cmd_address_o=0, data_cmd_data_o=0, cpu_rsp_data_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation with no CPU response.
REQ-034 After a mid-operation reset, a late data_rsp_ready_i SHALL be ignored.

Structure
REQ-035 Package sddr_pkg SHALL hold the FSM state enum, WORD_BITS=32, WORDS_PER_LINE=4 and LINE_OFFSET_BITS=4.
REQ-036 The byte merge SHALL be a sub-module sddr_line_merge (line, word index, data, mask -> merged line).

Verification
REQ-037 Read miss: read addr 0x40, controller returns line 0x...4444_3333_2222_1111 -> one read cmd at address 0x40, rsp data 0x1111 zero-extended per word[0], rsp 1 cycle after pulse.
REQ-038 Read hit: read 0x48 directly after -> no DDR cmd, rsp in N+1 with word[2] = 0x3333.
REQ-039 Write miss: write 0x104 data 0xAABBCCDD mask 4'b0011 over line word1=0x12345678 -> read cmd then write cmd at 0x100, word1 = 0x1234CCDD, rsp after write ack.
REQ-040 Backpressure: hold data_cmd_ack_i=0 for 10 cycles -> command fields stable throughout, cpu_req_ack_o=0.
REQ-041 Reset in RD_WAIT, then stray data_rsp_ready_i -> no cpu_rsp_valid_o, next read of the same address misses.
REQ-042 Mask 0 write -> rsp in N+1, no DDR command.
